// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: bundle of the exception sequencer's pipeline/cp0 signals.
//   master : pipeline + cp0 side (drives requests, PCs, interrupt, EPC;
//            receives the cp0 write, flush, stall and PC redirect)
//   slave  : exc_ctrl side (the opposite directions)
interface exc_ctrl_if;
  logic        If_adel;
  logic [31:0] If_pc;
  logic        Id_sys;
  logic        Id_ri;
  logic        Id_eret;
  logic [31:0] Id_pc;
  logic        Ex_ov;
  logic [31:0] Ex_pc;
  logic        Mem_adel;
  logic        Mem_ades;
  logic        Mem_valid;
  logic [31:0] Mem_pc;
  logic        Cp0_intr;
  logic [31:0] Cp0_epc;
  logic        Cu_cp0_w_en;
  logic [4:0]  Cu_exec_code;
  logic [31:0] Epc;
  logic [3:0]  Flush;
  logic        Stall;
  logic        Pc_redirect;
  logic [31:0] Pc_target;

  modport master (
    output If_adel, If_pc, Id_sys, Id_ri, Id_eret, Id_pc, Ex_ov, Ex_pc,
           Mem_adel, Mem_ades, Mem_valid, Mem_pc, Cp0_intr, Cp0_epc,
    input  Cu_cp0_w_en, Cu_exec_code, Epc, Flush, Stall, Pc_redirect, Pc_target
  );

  modport slave (
    input  If_adel, If_pc, Id_sys, Id_ri, Id_eret, Id_pc, Ex_ov, Ex_pc,
           Mem_adel, Mem_ades, Mem_valid, Mem_pc, Cp0_intr, Cp0_epc,
    output Cu_cp0_w_en, Cu_exec_code, Epc, Flush, Stall, Pc_redirect, Pc_target
  );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt sequencer for the 5-stage pipeline.
// Picks the highest-priority request among IF/ID/EX/MEM faults and the
// cp0 interrupt, flushes the faulting and younger stages, writes cause and
// EPC into cp0, then redirects the PC to the handler. ERET redirects the PC
// to cp0's EPC.
//   Clk   : clock, rising edge
//   Rst_n : asynchronous active-low reset
//   bus   : exc_ctrl_if.slave (requests and PCs in; cp0 write, Flush,
//           Stall, Pc_redirect/Pc_target out), all outputs registered
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
  parameter logic [4:0]  CODE_INT     = 5'd0,
  parameter logic [4:0]  CODE_ADEL    = 5'd4,
  parameter logic [4:0]  CODE_ADES    = 5'd5,
  parameter logic [4:0]  CODE_SYS     = 5'd8,
  parameter logic [4:0]  CODE_RI      = 5'd10,
  parameter logic [4:0]  CODE_OV      = 5'd12
) (
  input logic         Clk,
  input logic         Rst_n,
  exc_ctrl_if.slave   bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_COMMIT   = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;
  localparam logic [1:0] S_ERET_RD  = 2'd3;

  logic [1:0]  state;
  logic        w_en_q;
  logic [4:0]  code_q;
  logic [31:0] epc_q;
  logic [3:0]  flush_q;
  logic        stall_q;
  logic        redirect_q;
  logic [31:0] target_q;

  logic        take;
  logic        take_eret;
  logic [4:0]  sel_code;
  logic [31:0] sel_epc;
  logic [3:0]  sel_flush;

  // Priority pick. An interrupt only counts when MEM holds a real
  // instruction to attach the EPC to; otherwise it is simply deferred.
  always_comb begin
    take      = 1'b1;
    take_eret = 1'b0;
    sel_code  = CODE_INT;
    sel_epc   = bus.Mem_pc;
    sel_flush = 4'b1111;
    if (bus.Cp0_intr && bus.Mem_valid) begin
      sel_code = CODE_INT;
    end else if (bus.Mem_adel) begin
      sel_code = CODE_ADEL;
    end else if (bus.Mem_ades) begin
      sel_code = CODE_ADES;
    end else if (bus.Ex_ov) begin
      sel_code  = CODE_OV;
      sel_epc   = bus.Ex_pc;
      sel_flush = 4'b0111;
    end else if (bus.Id_ri) begin
      sel_code  = CODE_RI;
      sel_epc   = bus.Id_pc;
      sel_flush = 4'b0011;
    end else if (bus.Id_sys) begin
      sel_code  = CODE_SYS;
      sel_epc   = bus.Id_pc;
      sel_flush = 4'b0011;
    end else if (bus.If_adel) begin
      sel_code  = CODE_ADEL;
      sel_epc   = bus.If_pc;
      sel_flush = 4'b0001;
    end else begin
      take      = 1'b0;
      take_eret = bus.Id_eret;
    end
  end

  // Strobes default low every cycle so each pulse lasts exactly one cycle;
  // code/EPC are only written on acceptance and otherwise hold.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= S_IDLE;
      w_en_q     <= 1'b0;
      code_q     <= 5'd0;
      epc_q      <= 32'd0;
      flush_q    <= 4'd0;
      stall_q    <= 1'b0;
      redirect_q <= 1'b0;
      target_q   <= 32'd0;
    end else begin
      w_en_q     <= 1'b0;
      flush_q    <= 4'd0;
      stall_q    <= 1'b0;
      redirect_q <= 1'b0;
      target_q   <= 32'd0;
      case (state)
        S_IDLE: begin
          if (take) begin
            state   <= S_COMMIT;
            code_q  <= sel_code;
            epc_q   <= sel_epc;
            flush_q <= sel_flush;
            stall_q <= 1'b1;
            w_en_q  <= 1'b1;
          end else if (take_eret) begin
            state   <= S_ERET_RD;
            flush_q <= 4'b0001;
          end
        end
        S_COMMIT: begin
          state      <= S_REDIRECT;
          stall_q    <= 1'b1;
          redirect_q <= 1'b1;
          target_q   <= HANDLER_ADDR;
        end
        S_REDIRECT: begin
          state <= S_IDLE;
        end
        default: begin
          // ERET_RD: EPC is sampled here, so a cp0 update landing during
          // the flush cycle is still honoured.
          state      <= S_IDLE;
          redirect_q <= 1'b1;
          target_q   <= bus.Cp0_epc;
        end
      endcase
    end
  end

  assign bus.Cu_cp0_w_en  = w_en_q;
  assign bus.Cu_exec_code = code_q;
  assign bus.Epc          = epc_q;
  assign bus.Flush        = flush_q;
  assign bus.Stall        = stall_q;
  assign bus.Pc_redirect  = redirect_q;
  assign bus.Pc_target    = target_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: table-driven directed test of exc_ctrl plus hand-written
// sequences for ignored requests, mid-sequence reset and deferred interrupts.
module tb_exc_ctrl;

  localparam logic [31:0] IF_PC   = 32'h0040_0003;
  localparam logic [31:0] ID_PC   = 32'h0040_0008;
  localparam logic [31:0] EX_PC   = 32'h0040_0010;
  localparam logic [31:0] MEM_PC  = 32'h0040_0020;
  localparam logic [31:0] ERET_PC = 32'h1234_5678;
  localparam logic [31:0] HANDLER = 32'h0000_0080;

  // kind: 0 = no response, 1 = exception, 2 = eret
  typedef struct {
    string       name;
    int          kind;
    logic        intr, mval, madel, mades, exov, idri, idsys, ifadel, ideret;
    logic [3:0]  flush;
    logic [4:0]  code;
    logic [31:0] epc;
  } vec_t;

  logic Clk;
  logic Rst_n;
  int   total;
  int   bad;
  logic [4:0]  model_code;
  logic [31:0] model_epc;
  vec_t vecs[12];

  exc_ctrl_if bus ();

  exc_ctrl dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t mk(string name, int kind, logic [8:0] req,
                              logic [3:0] flush, logic [4:0] code,
                              logic [31:0] epc);
    vec_t v;
    v.name = name;
    v.kind = kind;
    {v.intr, v.mval, v.madel, v.mades, v.exov,
     v.idri, v.idsys, v.ifadel, v.ideret} = req;
    v.flush = flush;
    v.code  = code;
    v.epc   = epc;
    return v;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(logic [8:0] req);
    {bus.Cp0_intr, bus.Mem_valid, bus.Mem_adel, bus.Mem_ades, bus.Ex_ov,
     bus.Id_ri, bus.Id_sys, bus.If_adel, bus.Id_eret} = req;
  endtask

  task automatic checkQuiet(string name);
    checkOutput({name, ".w_en"},     32'(bus.Cu_cp0_w_en), 32'd0);
    checkOutput({name, ".flush"},    32'(bus.Flush),       32'd0);
    checkOutput({name, ".stall"},    32'(bus.Stall),       32'd0);
    checkOutput({name, ".redirect"}, 32'(bus.Pc_redirect), 32'd0);
  endtask

  task automatic runVec(vec_t v);
    @(negedge Clk);
    applyStimulus({v.intr, v.mval, v.madel, v.mades, v.exov,
                   v.idri, v.idsys, v.ifadel, v.ideret});
    @(posedge Clk); #1;
    applyStimulus(9'd0);
    if (v.kind == 1) begin
      model_code = v.code;
      model_epc  = v.epc;
      checkOutput({v.name, ".flush"}, 32'(bus.Flush),        32'(v.flush));
      checkOutput({v.name, ".w_en"},  32'(bus.Cu_cp0_w_en),  32'd1);
      checkOutput({v.name, ".stall"}, 32'(bus.Stall),        32'd1);
      checkOutput({v.name, ".code"},  32'(bus.Cu_exec_code), 32'(model_code));
      checkOutput({v.name, ".epc"},   bus.Epc,               model_epc);
      @(posedge Clk); #1;
      checkOutput({v.name, ".redir"},   32'(bus.Pc_redirect), 32'd1);
      checkOutput({v.name, ".target"},  bus.Pc_target,        HANDLER);
      checkOutput({v.name, ".stall2"},  32'(bus.Stall),       32'd1);
      checkOutput({v.name, ".w_en2"},   32'(bus.Cu_cp0_w_en), 32'd0);
      checkOutput({v.name, ".flush2"},  32'(bus.Flush),       32'd0);
    end else if (v.kind == 2) begin
      checkOutput({v.name, ".flush"}, 32'(bus.Flush),       32'h1);
      checkOutput({v.name, ".w_en"},  32'(bus.Cu_cp0_w_en), 32'd0);
      checkOutput({v.name, ".stall"}, 32'(bus.Stall),       32'd0);
      @(posedge Clk); #1;
      checkOutput({v.name, ".redir"},  32'(bus.Pc_redirect), 32'd1);
      checkOutput({v.name, ".target"}, bus.Pc_target,        ERET_PC);
      checkOutput({v.name, ".w_en2"},  32'(bus.Cu_cp0_w_en), 32'd0);
      checkOutput({v.name, ".stall2"}, 32'(bus.Stall),       32'd0);
    end else begin
      checkQuiet(v.name);
    end
    @(posedge Clk); #1;
    checkQuiet({v.name, ".idle"});
    checkOutput({v.name, ".hold_code"}, 32'(bus.Cu_exec_code), 32'(model_code));
    checkOutput({v.name, ".hold_epc"},  bus.Epc,               model_epc);
  endtask

  initial begin
    int pulses;
    total = 0;
    bad   = 0;
    model_code = 5'd0;
    model_epc  = 32'd0;
    bus.If_pc   = IF_PC;
    bus.Id_pc   = ID_PC;
    bus.Ex_pc   = EX_PC;
    bus.Mem_pc  = MEM_PC;
    bus.Cp0_epc = ERET_PC;
    applyStimulus(9'd0);

    //                         intr mval madel mades exov idri idsys ifadel eret
    vecs[0]  = mk("ov",        1, 9'b0_0_0_0_1_0_0_0_0, 4'b0111, 5'd12, EX_PC);
    vecs[1]  = mk("intr_sys",  1, 9'b1_1_0_0_0_0_1_0_0, 4'b1111, 5'd0,  MEM_PC);
    vecs[2]  = mk("adel_ades", 1, 9'b0_1_1_1_0_0_0_0_0, 4'b1111, 5'd4,  MEM_PC);
    vecs[3]  = mk("ades",      1, 9'b0_1_0_1_0_0_0_0_0, 4'b1111, 5'd5,  MEM_PC);
    vecs[4]  = mk("if_adel",   1, 9'b0_0_0_0_0_0_0_1_0, 4'b0001, 5'd4,  IF_PC);
    vecs[5]  = mk("ri_sys",    1, 9'b0_0_0_0_0_1_1_0_0, 4'b0011, 5'd10, ID_PC);
    vecs[6]  = mk("sys_ifadel",1, 9'b0_0_0_0_0_0_1_1_0, 4'b0011, 5'd8,  ID_PC);
    vecs[7]  = mk("eret",      2, 9'b0_0_0_0_0_0_0_0_1, 4'b0001, 5'd0,  32'd0);
    vecs[8]  = mk("eret_ov",   1, 9'b0_0_0_0_1_0_0_0_1, 4'b0111, 5'd12, EX_PC);
    vecs[9]  = mk("intr_nv_ov",1, 9'b1_0_0_0_1_0_0_0_0, 4'b0111, 5'd12, EX_PC);
    vecs[10] = mk("intr_nv",   0, 9'b1_0_0_0_0_0_0_0_0, 4'b0000, 5'd0,  32'd0);
    vecs[11] = mk("mem_ov",    1, 9'b0_1_1_0_1_0_0_0_0, 4'b1111, 5'd4,  MEM_PC);

    Rst_n = 1'b0;
    #12;
    checkOutput("rst.w_en",     32'(bus.Cu_cp0_w_en),  32'd0);
    checkOutput("rst.code",     32'(bus.Cu_exec_code), 32'd0);
    checkOutput("rst.epc",      bus.Epc,               32'd0);
    checkOutput("rst.flush",    32'(bus.Flush),        32'd0);
    checkOutput("rst.stall",    32'(bus.Stall),        32'd0);
    checkOutput("rst.redirect", 32'(bus.Pc_redirect),  32'd0);
    checkOutput("rst.target",   bus.Pc_target,         32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < 12; i++) runVec(vecs[i]);

    // Id_ri arriving during COMMIT/REDIRECT must be dropped.
    @(negedge Clk);
    applyStimulus(9'b0_0_0_0_1_0_0_0_0);
    @(negedge Clk);
    applyStimulus(9'b0_0_0_0_0_1_0_0_0);
    pulses = (bus.Cu_cp0_w_en === 1'b1) ? 1 : 0;
    checkOutput("ign.code", 32'(bus.Cu_exec_code), 32'd12);
    @(negedge Clk);
    if (bus.Cu_cp0_w_en === 1'b1) pulses++;
    @(negedge Clk);
    applyStimulus(9'd0);
    for (int i = 0; i < 4; i++) begin
      if (bus.Cu_cp0_w_en === 1'b1) pulses++;
      @(negedge Clk);
    end
    checkOutput("ign.pulses",    32'(pulses), 32'd1);
    checkOutput("ign.code_hold", 32'(bus.Cu_exec_code), 32'd12);
    model_code = 5'd12;
    model_epc  = EX_PC;

    // Reset dropped during COMMIT clears everything at once.
    applyStimulus(9'b0_0_0_0_0_0_1_0_0);
    @(posedge Clk); #1;
    applyStimulus(9'd0);
    checkOutput("mid.w_en_before", 32'(bus.Cu_cp0_w_en), 32'd1);
    #2;
    Rst_n = 1'b0;
    #1;
    checkOutput("mid.w_en",   32'(bus.Cu_cp0_w_en),  32'd0);
    checkOutput("mid.flush",  32'(bus.Flush),        32'd0);
    checkOutput("mid.stall",  32'(bus.Stall),        32'd0);
    checkOutput("mid.code",   32'(bus.Cu_exec_code), 32'd0);
    checkOutput("mid.epc",    bus.Epc,               32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_code = 5'd0;
    model_epc  = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      checkQuiet($sformatf("post_rst%0d", i));
    end

    // Interrupt waits for a valid MEM instruction.
    @(negedge Clk);
    applyStimulus(9'b1_0_0_0_0_0_0_0_0);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      checkQuiet($sformatf("defer%0d", i));
    end
    @(negedge Clk);
    bus.Mem_valid = 1'b1;
    @(posedge Clk); #1;
    applyStimulus(9'd0);
    checkOutput("defer.w_en",  32'(bus.Cu_cp0_w_en),  32'd1);
    checkOutput("defer.code",  32'(bus.Cu_exec_code), 32'd0);
    checkOutput("defer.epc",   bus.Epc,               MEM_PC);
    checkOutput("defer.flush", 32'(bus.Flush),        32'hF);
    @(posedge Clk); #1;
    checkOutput("defer.redir", 32'(bus.Pc_redirect),  32'd1);
    @(posedge Clk); #1;
    checkQuiet("defer.idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
